// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises an external I2S bus into MasterCLK, assembles
// {left,right} frames (Philips one-bit delay) and queues them in a FWFT FIFO.
module i2s_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                       MasterCLK,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       I2S_CLK,
    input  logic                       I2S_WS,
    input  logic                       I2S_DATA,
    output logic [2*SAMPLE_BITS-1:0]   OutputData,
    output logic                       OutputValid,
    input  logic                       OutputReady,
    output logic                       Overflow,
    output logic                       FrameError
);

    localparam int             AW   = $clog2(FIFO_DEPTH);
    localparam logic [5:0]     SB   = 6'(SAMPLE_BITS);
    localparam logic [AW:0]    FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} state_t;

    state_t                    state;
    logic [SYNC_STAGES-1:0]    sck_sync, ws_sync, sd_sync;
    logic                      sck_prev, sck_rise, d_cap, w_cap, w_prev;
    logic [4:0]                bit_cnt;
    logic [SAMPLE_BITS-1:0]    shreg, left_word, word;
    logic                      boundary, keep_bit, short_word;
    logic                      frame_push;
    logic [2*SAMPLE_BITS-1:0]  frame_data;
    logic [2*SAMPLE_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]             rd_ptr, wr_ptr;
    logic [AW:0]               count;
    logic                      pop, push_ok;

    // Strobe is registered so d_cap/w_cap line up with it one cycle after the synchronisers.
    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
            sck_rise <= 1'b0;
            d_cap    <= 1'b0;
            w_cap    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], I2S_CLK};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], I2S_WS};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], I2S_DATA};
            sck_prev <= sck_sync[SYNC_STAGES-1];
            sck_rise <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
            d_cap    <= sd_sync[SYNC_STAGES-1];
            w_cap    <= ws_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        boundary   = (w_cap != w_prev);
        keep_bit   = ({1'b0, bit_cnt} < SB);
        word       = keep_bit ? {shreg[SAMPLE_BITS-2:0], d_cap} : shreg;
        short_word = (({1'b0, bit_cnt} + 6'd1) < SB);
    end

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            w_prev     <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            left_word  <= '0;
            frame_push <= 1'b0;
            frame_data <= '0;
            FrameError <= 1'b0;
        end else begin
            frame_push <= 1'b0;
            FrameError <= 1'b0;
            if (sck_rise) begin
                w_prev <= w_cap;
                if (boundary) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    shreg <= word;
                    if (bit_cnt != 5'd31)
                        bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (!Enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:  state <= ALIGN;
                    ALIGN: if (sck_rise && boundary && !w_cap) state <= LEFT;
                    LEFT: begin
                        if (sck_rise && boundary) begin
                            if (short_word) begin
                                FrameError <= 1'b1;
                                state      <= ALIGN;
                            end else begin
                                left_word <= word;
                                state     <= RIGHT;
                            end
                        end
                    end
                    RIGHT: begin
                        if (sck_rise && boundary) begin
                            if (short_word) begin
                                FrameError <= 1'b1;
                                state      <= ALIGN;
                            end else begin
                                frame_data <= {left_word, word};
                                frame_push <= 1'b1;
                                state      <= LEFT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        pop     = OutputValid && OutputReady;
        push_ok = frame_push && ((count != FULL) || pop);
    end

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (!Enable) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= frame_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (frame_push && !push_ok)
                Overflow <= 1'b1;
        end
    end

    assign OutputData  = mem[rd_ptr];
    assign OutputValid = (count != '0);

endmodule
